// File: rtl/aes_gcm_instance_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : aes_gcm_instance_sequencer
// Brief   : Turns one instance command plus its AAD/PT block stream into
//           framed single-cycle beats for the AES-GCM key-expansion stage.
// Revision: 1.0 - initial release
// ============================================================================
module aes_gcm_instance_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [0:127]     i_cmd_key,
  input  logic [0:95]      i_cmd_iv,
  input  logic [CNT_W-1:0] i_cmd_aad_blocks,
  input  logic [CNT_W-1:0] i_cmd_pt_blocks,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic [0:127]     i_data,
  output logic             o_valid,
  output logic [0:127]     o_cipher_key,
  output logic [0:95]      o_iv,
  output logic [0:127]     o_aad,
  output logic [0:127]     o_plain_text,
  output logic [0:127]     o_instance_size,
  output logic             o_new_instance,
  output logic             o_pt_instance,
  output logic             o_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AAD  = 2'd1,
    S_PT   = 2'd2,
    S_NULL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_aad_cnt;
  logic [CNT_W-1:0] r_pt_cnt;
  logic [CNT_W-1:0] w_aad_cnt_nxt;
  logic [CNT_W-1:0] w_pt_cnt_nxt;
  logic             r_first;
  logic             w_cmd_acc;
  logic             w_data_acc;
  logic             w_beat;
  logic             w_beat_aad;
  logic             w_beat_pt;
  logic             w_beat_last;
  logic [63:0]      w_aad_bits;
  logic [63:0]      w_pt_bits;

  // Readies are gated by reset so nothing is accepted while it is asserted.
  assign o_cmd_ready  = i_rst_n && (r_state == S_IDLE);
  assign o_data_ready = i_rst_n && ((r_state == S_AAD) || (r_state == S_PT));
  assign w_cmd_acc    = i_cmd_valid && o_cmd_ready;
  assign w_data_acc   = i_data_valid && o_data_ready;

  assign w_aad_bits = 64'(i_cmd_aad_blocks) << 7;
  assign w_pt_bits  = 64'(i_cmd_pt_blocks) << 7;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_aad_cnt <= '0;
      r_pt_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_aad_cnt <= w_aad_cnt_nxt;
      r_pt_cnt  <= w_pt_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_aad_cnt_nxt = r_aad_cnt;
    w_pt_cnt_nxt  = r_pt_cnt;
    w_beat        = 1'b0;
    w_beat_aad    = 1'b0;
    w_beat_pt     = 1'b0;
    w_beat_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          w_aad_cnt_nxt = i_cmd_aad_blocks;
          w_pt_cnt_nxt  = i_cmd_pt_blocks;
          if (i_cmd_aad_blocks != '0)
            w_state_nxt = S_AAD;
          else if (i_cmd_pt_blocks != '0)
            w_state_nxt = S_PT;
          else
            w_state_nxt = S_NULL;
        end
      end
      S_AAD: begin
        if (w_data_acc) begin
          w_beat        = 1'b1;
          w_beat_aad    = 1'b1;
          w_aad_cnt_nxt = r_aad_cnt - c_one;
          if (r_aad_cnt == c_one) begin
            if (r_pt_cnt != '0) begin
              w_state_nxt = S_PT;
            end else begin
              w_state_nxt = S_IDLE;
              w_beat_last = 1'b1;
            end
          end
        end
      end
      S_PT: begin
        if (w_data_acc) begin
          w_beat       = 1'b1;
          w_beat_pt    = 1'b1;
          w_pt_cnt_nxt = r_pt_cnt - c_one;
          if (r_pt_cnt == c_one) begin
            w_state_nxt = S_IDLE;
            w_beat_last = 1'b1;
          end
        end
      end
      default: begin
        // Empty instance: one framing-only beat, no data consumed.
        w_beat      = 1'b1;
        w_beat_last = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_first         <= 1'b0;
      o_valid         <= 1'b0;
      o_new_instance  <= 1'b0;
      o_pt_instance   <= 1'b0;
      o_done          <= 1'b0;
      o_busy          <= 1'b0;
      o_aad           <= '0;
      o_plain_text    <= '0;
      o_cipher_key    <= '0;
      o_iv            <= '0;
      o_instance_size <= '0;
    end else begin
      o_valid        <= w_beat;
      o_new_instance <= w_beat && r_first;
      o_pt_instance  <= w_beat_pt;
      o_done         <= w_beat_last;
      o_busy         <= (w_state_nxt != S_IDLE);
      o_aad          <= w_beat_aad ? i_data : '0;
      o_plain_text   <= w_beat_pt ? i_data : '0;
      if (w_cmd_acc) begin
        r_first         <= 1'b1;
        o_cipher_key    <= i_cmd_key;
        o_iv            <= i_cmd_iv;
        o_instance_size <= {w_aad_bits, w_pt_bits};
      end else if (w_beat) begin
        r_first <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_gcm_instance_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_gcm_instance_sequencer
// Brief   : Self-checking bench: directed vector table, reset corner case and
//           randomized instances against a block-list reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_gcm_instance_sequencer;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [0:127]     i_cmd_key;
  logic [0:95]      i_cmd_iv;
  logic [CNT_W-1:0] i_cmd_aad_blocks;
  logic [CNT_W-1:0] i_cmd_pt_blocks;
  logic             i_data_valid;
  logic             o_data_ready;
  logic [0:127]     i_data;
  logic             o_valid;
  logic [0:127]     o_cipher_key;
  logic [0:95]      o_iv;
  logic [0:127]     o_aad;
  logic [0:127]     o_plain_text;
  logic [0:127]     o_instance_size;
  logic             o_new_instance;
  logic             o_pt_instance;
  logic             o_done;
  logic             o_busy;

  always #5 clk = ~clk;

  aes_gcm_instance_sequencer #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .i_rst_n          (i_rst_n),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_cmd_key        (i_cmd_key),
    .i_cmd_iv         (i_cmd_iv),
    .i_cmd_aad_blocks (i_cmd_aad_blocks),
    .i_cmd_pt_blocks  (i_cmd_pt_blocks),
    .i_data_valid     (i_data_valid),
    .o_data_ready     (o_data_ready),
    .i_data           (i_data),
    .o_valid          (o_valid),
    .o_cipher_key     (o_cipher_key),
    .o_iv             (o_iv),
    .o_aad            (o_aad),
    .o_plain_text     (o_plain_text),
    .o_instance_size  (o_instance_size),
    .o_new_instance   (o_new_instance),
    .o_pt_instance    (o_pt_instance),
    .o_done           (o_done),
    .o_busy           (o_busy)
  );

  typedef struct {
    int           aad;
    int           pt;
    int           gap;        // 0 continuous, 1 toggle 1,0,1.., 2 random
    int           exp_beats;
    logic [0:127] exp_size;
  } vec_t;

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_beat(input logic [0:127] key, input logic [0:95] iv,
                          input logic [0:127] size, input logic [0:127] exp_aad,
                          input logic [0:127] exp_pt, input logic exp_pti,
                          input logic exp_new, input logic exp_done);
    chk("beat_valid", o_valid, 1);
    chk("beat_key", o_cipher_key, key);
    chk("beat_iv", o_iv, iv);
    chk("beat_size", o_instance_size, size);
    chk("beat_aad", o_aad, exp_aad);
    chk("beat_plain", o_plain_text, exp_pt);
    chk("beat_pt_instance", o_pt_instance, exp_pti);
    chk("beat_new_instance", o_new_instance, exp_new);
    chk("beat_done", o_done, exp_done);
  endtask

  // Model: an instance is the ordered list of its blocks, AAD first, then PT.
  task automatic run_inst(input int aad, input int pt, input int gap,
                          input int exp_beats, input logic [0:127] exp_size);
    logic [0:127] key;
    logic [0:95]  iv;
    logic [0:127] blocks[$];
    logic         dv;
    logic         tog;
    logic         is_pt;
    int           n;
    int           bi;
    int           beats;
    int           cycles;
    key = rand128();
    iv  = {$urandom, $urandom, $urandom};
    n   = aad + pt;
    for (int i = 0; i < n; i++) blocks.push_back(rand128());

    @(negedge clk);
    chk("cmd_ready_idle", o_cmd_ready, 1);
    if (o_cmd_ready !== 1'b1) return;
    i_cmd_valid      = 1'b1;
    i_cmd_key        = key;
    i_cmd_iv         = iv;
    i_cmd_aad_blocks = CNT_W'(aad);
    i_cmd_pt_blocks  = CNT_W'(pt);
    @(posedge clk);
    #1;
    i_cmd_valid      = 1'b0;
    i_cmd_key        = rand128();
    i_cmd_iv         = {$urandom, $urandom, $urandom};
    i_cmd_aad_blocks = CNT_W'($urandom);
    i_cmd_pt_blocks  = CNT_W'($urandom);
    chk("no_beat_on_accept", o_valid, 0);
    chk("busy_after_accept", o_busy, 1);

    beats = 0;
    if (n == 0) begin
      chk("null_data_ready", o_data_ready, 0);
      @(negedge clk);
      i_data_valid = 1'b1;
      i_data       = rand128();
      chk("null_data_ready", o_data_ready, 0);
      @(posedge clk);
      #1;
      i_data_valid = 1'b0;
      if (o_valid) beats++;
      chk_beat(key, iv, exp_size, '0, '0, 1'b0, 1'b1, 1'b1);
    end else begin
      bi     = 0;
      cycles = 0;
      tog    = 1'b1;
      while (bi < n && cycles < 200) begin
        @(negedge clk);
        dv  = (gap == 0) ? 1'b1 : (gap == 1) ? tog : 1'($urandom_range(0, 1));
        tog = ~tog;
        i_data_valid = dv;
        i_data       = dv ? blocks[bi] : rand128();
        chk("data_ready", o_data_ready, 1);
        @(posedge clk);
        #1;
        i_data_valid = 1'b0;
        if (o_valid) beats++;
        if (dv) begin
          is_pt = (bi >= aad);
          chk_beat(key, iv, exp_size, is_pt ? '0 : blocks[bi], is_pt ? blocks[bi] : '0,
                   is_pt, bi == 0, bi == n - 1);
          bi++;
        end else begin
          chk("gap_valid", o_valid, 0);
        end
        cycles++;
      end
      if (bi < n) chk("instance_timeout", bi, n);
    end
    chk("beat_count", beats, exp_beats);
    chk("cmd_ready_after_done", o_cmd_ready, 1);
    chk("busy_after_done", o_busy, 0);
    chk("data_ready_after_done", o_data_ready, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_new"}, o_new_instance, 0);
    chk({tag, "_pti"}, o_pt_instance, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_aad"}, o_aad, 0);
    chk({tag, "_plain"}, o_plain_text, 0);
    chk({tag, "_key"}, o_cipher_key, 0);
    chk({tag, "_iv"}, o_iv, 0);
    chk({tag, "_size"}, o_instance_size, 0);
  endtask

  initial begin
    int a;
    int p;
    vecs[0] = '{2, 3, 0, 5, 128'h0000_0000_0000_0100_0000_0000_0000_0180};
    vecs[1] = '{0, 1, 0, 1, 128'h0000_0000_0000_0000_0000_0000_0000_0080};
    vecs[2] = '{0, 0, 0, 1, 128'h0};
    vecs[3] = '{1, 2, 1, 3, 128'h0000_0000_0000_0080_0000_0000_0000_0100};
    vecs[4] = '{1, 1, 0, 2, 128'h0000_0000_0000_0080_0000_0000_0000_0080};
    vecs[5] = '{1, 1, 0, 2, 128'h0000_0000_0000_0080_0000_0000_0000_0080};

    i_rst_n          = 1'b0;
    i_cmd_valid      = 1'b1;
    i_cmd_key        = '1;
    i_cmd_iv         = '1;
    i_cmd_aad_blocks = CNT_W'(3);
    i_cmd_pt_blocks  = CNT_W'(3);
    i_data_valid     = 1'b1;
    i_data           = '1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_cmd_ready", o_cmd_ready, 0);
    chk("reset_data_ready", o_data_ready, 0);
    @(negedge clk);
    i_cmd_valid  = 1'b0;
    i_data_valid = 1'b0;
    i_rst_n      = 1'b1;
    #1;
    chk("idle_cmd_ready", o_cmd_ready, 1);
    chk("idle_data_ready", o_data_ready, 0);

    foreach (vecs[i]) run_inst(vecs[i].aad, vecs[i].pt, vecs[i].gap, vecs[i].exp_beats, vecs[i].exp_size);

    // Reset during the PT phase of a (2,4) instance abandons it.
    @(negedge clk);
    i_cmd_valid      = 1'b1;
    i_cmd_key        = rand128();
    i_cmd_iv         = {$urandom, $urandom, $urandom};
    i_cmd_aad_blocks = CNT_W'(2);
    i_cmd_pt_blocks  = CNT_W'(4);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      i_data_valid = 1'b1;
      i_data       = rand128();
      @(posedge clk);
      #1;
    end
    chk("pre_reset_pt_beat", o_pt_instance, 1);
    chk("pre_reset_no_done", o_done, 0);
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    chk("rst_low_cmd_ready", o_cmd_ready, 0);
    chk("rst_low_data_ready", o_data_ready, 0);
    @(posedge clk);
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    i_data_valid = 1'b0;
    i_rst_n      = 1'b1;
    #1;
    chk("post_reset_cmd_ready", o_cmd_ready, 1);
    run_inst(1, 0, 0, 1, 128'h0000_0000_0000_0080_0000_0000_0000_0000);

    for (int r = 0; r < 25; r++) begin
      a = $urandom_range(0, 4);
      p = $urandom_range(0, 4);
      run_inst(a, p, $urandom_range(0, 2), (a + p == 0) ? 1 : a + p,
               {64'(a) * 64'd128, 64'(p) * 64'd128});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
